ram_512x32: RTL and testbench

//   Single-port 512-word x 32-bit synchronous data memory for the MiniSRC processor datapath.
//   The memory controller drives read/write strobes, a 9-bit word address and write data.
//   All accesses complete on the rising clock edge.

---
 rtl/ram_512x32.sv | 44 ++++
 tb/tb_ram_512x32.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ram_512x32.sv
// ram_512x32: 512 x 32 single-port synchronous data memory.
// Registered read data, write-first on simultaneous read/write.
module ram_512x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clck,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  reset
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array: reset clears every word in one cycle, else write.
    always_ff @(posedge clck) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[addr] <= data_in;
        end
    end

    // Read register: write-first bypass when both strobes are high.
    always_ff @(posedge clck) begin
        if (reset) begin
            data_out <= '0;
        end else if (write) begin
            if (read) begin
                data_out <= data_in;
            end
        end else if (read) begin
            data_out <= mem[addr];
        end
    end

endmodule

// File: tb/tb_ram_512x32.sv
// tb_ram_512x32: directed self-checking bench for ram_512x32.
// Inputs change on falling edges; outputs sampled 1 unit after rising.
module tb_ram_512x32;

    logic        clck = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        reset = 1'b0;

    int compared = 0;
    int mismatched = 0;

    ram_512x32 dut (
        .clck     (clck),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .reset    (reset)
    );

    always #5 clck = ~clck;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op(input logic r, input logic w,
                      input logic [8:0] a, input logic [31:0] d);
        @(negedge clck);
        read = r;
        write = w;
        addr = a;
        data_in = d;
        @(posedge clck);
        #1;
        read = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        // power-up clear
        reset = 1'b1;
        op(1'b0, 1'b0, 9'd0, 32'd0);
        reset = 1'b0;
        check("reset_dout", data_out, 32'd0);

        // 1: read of cleared memory
        op(1'b1, 1'b0, 9'd0, 32'd0);
        check("t1_rd0", data_out, 32'd0);

        // 2: write 86 to addr 0, data_out untouched by write
        op(1'b0, 1'b1, 9'd0, 32'd86);
        check("t2_wr_hold", data_out, 32'd0);
        op(1'b1, 1'b0, 9'd0, 32'd0);
        check("t2_rd0", data_out, 32'd86);

        // 3: top address, no aliasing with addr 0
        op(1'b0, 1'b1, 9'd511, 32'd2);
        check("t3_wr_hold", data_out, 32'd86);
        op(1'b1, 1'b0, 9'd511, 32'd0);
        check("t3_rd511", data_out, 32'd2);
        op(1'b1, 1'b0, 9'd0, 32'd0);
        check("t3_rd0", data_out, 32'd86);
        op(1'b0, 1'b1, 9'd256, 32'hA5A5_0F0F);
        op(1'b1, 1'b0, 9'd256, 32'd0);
        check("t3_rd256", data_out, 32'hA5A5_0F0F);
        op(1'b1, 1'b0, 9'd0, 32'd0);
        check("t3_rd0_b", data_out, 32'd86);

        // 4: simultaneous read/write is write-first
        op(1'b1, 1'b1, 9'd5, 32'hDEAD_BEEF);
        check("t4_rw", data_out, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 9'd511, 32'd0);
        check("t4_rd511", data_out, 32'd2);
        op(1'b1, 1'b0, 9'd5, 32'd0);
        check("t4_rd5", data_out, 32'hDEAD_BEEF);

        // 6: idle cycles with toggling addr/data hold data_out
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b0, 9'(i * 37), 32'h1111_1111 * i);
            #2;
            addr = 9'd0;
            data_in = 32'hFFFF_FFFF;
            #1;
            check("t6_idle", data_out, 32'hDEAD_BEEF);
        end

        // mid-cycle strobe glitch is not sampled
        @(negedge clck);
        addr = 9'd0;
        read = 1'b1;
        #1;
        read = 1'b0;
        write = 1'b1;
        #1;
        write = 1'b0;
        @(posedge clck);
        #1;
        check("glitch", data_out, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 9'd0, 32'd0);
        check("glitch_mem", data_out, 32'd86);

        // 5: reset with a write in the same cycle
        reset = 1'b1;
        op(1'b1, 1'b1, 9'd7, 32'h1234_5678);
        reset = 1'b0;
        check("t5_dout", data_out, 32'd0);
        op(1'b1, 1'b0, 9'd0, 32'd0);
        check("t5_rd0", data_out, 32'd0);
        op(1'b1, 1'b0, 9'd5, 32'd0);
        check("t5_rd5", data_out, 32'd0);
        op(1'b1, 1'b0, 9'd511, 32'd0);
        check("t5_rd511", data_out, 32'd0);
        op(1'b1, 1'b0, 9'd256, 32'd0);
        check("t5_rd256", data_out, 32'd0);
        op(1'b1, 1'b0, 9'd7, 32'd0);
        check("t5_rd7", data_out, 32'd0);

        // memory still usable after reset
        op(1'b0, 1'b1, 9'd7, 32'h0BAD_F00D);
        op(1'b1, 1'b0, 9'd7, 32'd0);
        check("post_rd7", data_out, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
